nios2_dbg_scan_master: RTL and testbench

- Initiator side of the Nios II debug slave's virtual-JTAG link.
- Takes one command at a time over a valid/ready handshake. Each command is a 2-bit IR value plus a DR_WIDTH-bit data word.
- Drives the full virtual-JTAG sequence into the debug slave's tck/sysclk pair: update-IR, capture-DR, shift-DR, update-DR, run-test-idle.
- Returns the DR word shifted out of the slave. Used for in-fabric debug injection and as the debug-link driver in system benches.

---
 rtl/nios2_dbg_scan_master_if.sv | 35 +++
 rtl/nios2_dbg_scan_master.sv | 159 +++++++++++++++
 tb/tb_nios2_dbg_scan_master.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_dbg_scan_master_if.sv
// Command/response handshake and virtual-JTAG pins between the Nios II debug
// scan master and its user (master modport = scan master side).
interface nios2_dbg_scan_master_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;
    logic                busy;

    modport master (
        input  cmd_valid, cmd_ir, cmd_dr, vji_tdo,
        output cmd_ready, rsp_valid, rsp_dr, vji_tck, vji_tdi, vji_ir_in,
               vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, busy
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_dr, vji_tdo,
        input  cmd_ready, rsp_valid, rsp_dr, vji_tck, vji_tdi, vji_ir_in,
               vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, busy
    );
endinterface

// File: rtl/nios2_dbg_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave: UIR, CDR, SDR, UDR, RTI.
// NIOS2_DBG_SCAN_IR_CACHE_EN: skip the UIR period when the IR is unchanged.
module nios2_dbg_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input logic                     clk,
    input logic                     reset_n,
    nios2_dbg_scan_master_if.master bus
);
    localparam int PH_W = $clog2(2 * TCK_DIV);
    localparam int BC_W = $clog2(DR_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RSP
    } state_t;

    state_t              state_q;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [BC_W-1:0]     bcnt_q;
    logic [DR_WIDTH-1:0] shreg_q, rsp_dr_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic                tck_q, tck_d, tdi_q;
    logic                uir_q, cdr_q, sdr_q, udr_q, rti_q;
    logic                rsp_valid_q, busy_q, ready_q;
    logic                accept, per_end, tck_rise, skip_uir;

    // per_end: the coming edge starts a new tck period (tck falls).
    // tck_rise: the coming edge drives tck high, where tdo is sampled.
    always_comb begin
        per_end  = (ph_q == PH_W'(2 * TCK_DIV - 1));
        tck_rise = (ph_q == PH_W'(TCK_DIV - 1));
        ph_d     = per_end ? '0 : ph_q + PH_W'(1);
        tck_d    = (ph_d >= PH_W'(TCK_DIV));
        accept   = (state_q == S_IDLE) && bus.cmd_valid;
    end

`ifdef NIOS2_DBG_SCAN_IR_CACHE_EN
    logic irv_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    irv_q <= 1'b0;
        else if (accept) irv_q <= 1'b1;
    end

    assign skip_uir = irv_q && (bus.cmd_ir == ir_q);
`else
    assign skip_uir = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            rsp_dr_q    <= '0;
            ir_q        <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        ir_q    <= bus.cmd_ir;
                        shreg_q <= bus.cmd_dr;
                        ph_q    <= '0;
                        tck_q   <= 1'b0;
                        bcnt_q  <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        if (skip_uir) begin
                            state_q <= S_CDR;
                            cdr_q   <= 1'b1;
                        end else begin
                            state_q <= S_UIR;
                            uir_q   <= 1'b1;
                        end
                    end
                end
                S_RSP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    ph_q  <= ph_d;
                    tck_q <= tck_d;
                    if (tck_rise && state_q == S_SDR) begin
                        shreg_q <= {bus.vji_tdo, shreg_q[DR_WIDTH-1:1]};
                        bcnt_q  <= bcnt_q + BC_W'(1);
                    end
                    // Flags and tdi only move on the falling tck edge.
                    if (per_end) begin
                        uir_q <= 1'b0;
                        cdr_q <= 1'b0;
                        sdr_q <= 1'b0;
                        udr_q <= 1'b0;
                        rti_q <= 1'b0;
                        tdi_q <= 1'b0;
                        case (state_q)
                            S_UIR: begin
                                state_q <= S_CDR;
                                cdr_q   <= 1'b1;
                            end
                            S_CDR: begin
                                state_q <= S_SDR;
                                sdr_q   <= 1'b1;
                                tdi_q   <= shreg_q[0];
                            end
                            S_SDR: begin
                                if (bcnt_q == BC_W'(DR_WIDTH)) begin
                                    state_q <= S_UDR;
                                    udr_q   <= 1'b1;
                                    bcnt_q  <= '0;
                                end else begin
                                    sdr_q <= 1'b1;
                                    tdi_q <= shreg_q[0];
                                end
                            end
                            S_UDR: begin
                                state_q <= S_RTI;
                                rti_q   <= 1'b1;
                            end
                            default: begin
                                state_q     <= S_RSP;
                                rsp_valid_q <= 1'b1;
                                rsp_dr_q    <= shreg_q;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dr    = rsp_dr_q;
    assign bus.vji_tck   = tck_q;
    assign bus.vji_tdi   = tdi_q;
    assign bus.vji_ir_in = ir_q;
    assign bus.vji_uir   = uir_q;
    assign bus.vji_cdr   = cdr_q;
    assign bus.vji_sdr   = sdr_q;
    assign bus.vji_udr   = udr_q;
    assign bus.vji_rti   = rti_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_nios2_dbg_scan_master.sv
// Bench for nios2_dbg_scan_master: loopback instance (TCK_DIV=2) and slave-model
// instance (TCK_DIV=1), scoreboard of expected responses per instance.
module tb_nios2_dbg_scan_master;
    localparam int DW = 38;
    localparam int IW = 2;
    localparam logic [DW-1:0] SLV = 38'h3F_0000_0001;
`ifdef NIOS2_DBG_SCAN_IR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] dr;
        int            lat;
        int            uir;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nios2_dbg_scan_master_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) b1 ();
    nios2_dbg_scan_master_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) b2 ();

    nios2_dbg_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1.master));
    nios2_dbg_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .bus(b2.master));

    // Loopback: tdo returns the tdi seen one tck period earlier.
    logic lb_q;
    always @(posedge b1.vji_tck or negedge reset_n)
        if (!reset_n) lb_q <= 1'b0;
        else          lb_q <= b1.vji_tdi;
    assign b1.vji_tdo = lb_q;

    // Debug-slave model: captures SLV on CDR, shifts LSB first during SDR.
    logic [DW-1:0] sr_q;
    always @(posedge b2.vji_tck or negedge reset_n)
        if (!reset_n)        sr_q <= '0;
        else if (b2.vji_cdr) sr_q <= SLV;
        else if (b2.vji_sdr) sr_q <= {b2.vji_tdi, sr_q[DW-1:1]};
    assign b2.vji_tdo = sr_q[0];

    exp_t q1[$];
    exp_t q2[$];
    int   acc_log[$];
    int   rsp_log[$];
    bit            m_v = 1'b0;
    logic [IW-1:0] m_ir = '0;

    // Monitor for the loopback instance.
    logic tck_p1 = 1'b0, tdi_p1 = 1'b0, busy_p1 = 1'b0, rv_p1 = 1'b0;
    int   acc1, uir1, rsp_n1, tdi_bad, oh_bad, pulse_bad, idle_bad;
    exp_t e1;
    always begin
        @(negedge clk);
        if (reset_n) begin
            if (b1.busy && !busy_p1) begin
                acc1 = cyc;
                uir1 = 0;
                acc_log.push_back(cyc);
            end
            if (b1.vji_uir) uir1++;
            if (!$onehot0({b1.vji_uir, b1.vji_cdr, b1.vji_sdr, b1.vji_udr, b1.vji_rti})) oh_bad++;
            if (b1.vji_tdi !== tdi_p1 && !(tck_p1 && !b1.vji_tck)) tdi_bad++;
            if (b1.rsp_valid && rv_p1) pulse_bad++;
            if ((!b1.busy || b1.rsp_valid) &&
                (b1.vji_tck || b1.vji_uir || b1.vji_cdr || b1.vji_sdr || b1.vji_udr || b1.vji_rti))
                idle_bad++;
            if (b1.rsp_valid) begin
                rsp_n1++;
                rsp_log.push_back(cyc);
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp1_unexpected: got rsp_dr=%h with nothing outstanding", b1.rsp_dr);
                end else begin
                    e1 = q1.pop_front();
                    total++;
                    if (b1.rsp_dr !== e1.dr) begin
                        bad++; $display("FAIL rsp1_dr: got %h want %h", b1.rsp_dr, e1.dr);
                    end
                    total++;
                    if (cyc - acc1 !== e1.lat) begin
                        bad++; $display("FAIL rsp1_latency: got %0d want %0d", cyc - acc1, e1.lat);
                    end
                    total++;
                    if (uir1 !== e1.uir) begin
                        bad++; $display("FAIL rsp1_uir_cycles: got %0d want %0d", uir1, e1.uir);
                    end
                end
            end
        end
        tck_p1 = b1.vji_tck; tdi_p1 = b1.vji_tdi; busy_p1 = b1.busy; rv_p1 = b1.rsp_valid;
    end

    // Monitor for the slave-model instance: latency, per-flag cycles, order.
    logic busy_p2 = 1'b0;
    int   acc2, last2, oh_bad2, ord_bad2;
    int   fc2[5];
    int   ex_fc[5] = '{2, 2, 2 * DW, 2, 2};
    int   cur2;
    exp_t e2;
    always begin
        @(negedge clk);
        if (reset_n) begin
            if (b2.busy && !busy_p2) begin
                acc2 = cyc; last2 = 0;
                for (int k = 0; k < 5; k++) fc2[k] = 0;
            end
            if (!$onehot0({b2.vji_uir, b2.vji_cdr, b2.vji_sdr, b2.vji_udr, b2.vji_rti})) oh_bad2++;
            cur2 = b2.vji_uir ? 1 : b2.vji_cdr ? 2 : b2.vji_sdr ? 3 : b2.vji_udr ? 4 : b2.vji_rti ? 5 : 0;
            if (cur2 != 0) begin
                fc2[cur2-1]++;
                if (cur2 < last2) ord_bad2++;
                last2 = cur2;
            end
            if (b2.rsp_valid) begin
                if (q2.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp2_unexpected: got rsp_dr=%h", b2.rsp_dr);
                end else begin
                    e2 = q2.pop_front();
                    total++;
                    if (b2.rsp_dr !== e2.dr) begin
                        bad++; $display("FAIL rsp2_dr: got %h want %h", b2.rsp_dr, e2.dr);
                    end
                    total++;
                    if (cyc - acc2 !== e2.lat) begin
                        bad++; $display("FAIL rsp2_latency: got %0d want %0d", cyc - acc2, e2.lat);
                    end
                    for (int k = 0; k < 5; k++) begin
                        total++;
                        if (fc2[k] !== ex_fc[k]) begin
                            bad++; $display("FAIL rsp2_flag%0d_cycles: got %0d want %0d", k, fc2[k], ex_fc[k]);
                        end
                    end
                end
            end
        end
        busy_p2 = b2.busy;
    end

    // Expected result of a loopback scan; IR cache model decides whether UIR is skipped.
    task automatic push1(input logic [IW-1:0] ir, input logic [DW-1:0] dr);
        exp_t e;
        bit   hit;
        hit   = CACHE && m_v && (ir == m_ir);
        e.dr  = {dr[DW-2:0], 1'b0};
        e.lat = (hit ? DW + 3 : DW + 4) * 4;
        e.uir = hit ? 0 : 4;
        q1.push_back(e);
        m_v  = 1'b1;
        m_ir = ir;
    endtask

    task automatic cmd1(input logic [IW-1:0] ir, input logic [DW-1:0] dr);
        int n;
        @(negedge clk);
        b1.cmd_valid = 1'b1; b1.cmd_ir = ir; b1.cmd_dr = dr;
        n = 0;
        while (!b1.cmd_ready && n < 400) begin @(negedge clk); n++; end
        total++;
        if (!b1.cmd_ready) begin
            bad++; $display("FAIL cmd1_accept: cmd_ready=%b want 1", b1.cmd_ready);
            b1.cmd_valid = 1'b0;
            return;
        end
        push1(ir, dr);
        @(negedge clk);
        b1.cmd_valid = 1'b0;
    endtask

    task automatic drain1();
        int n;
        n = 0;
        while (!(q1.size() == 0 && b1.cmd_ready) && n < 1000) begin @(negedge clk); n++; end
        total++;
        if (q1.size() != 0 || !b1.cmd_ready) begin
            bad++; $display("FAIL drain1: outstanding=%0d cmd_ready=%b want 0/1", q1.size(), b1.cmd_ready);
            q1.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (b1.cmd_ready !== 1'b1 || b1.busy !== 1'b0 || b1.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_ctl: ready/busy/rsp=%b%b%b want 100", b1.cmd_ready, b1.busy, b1.rsp_valid);
        end
        total++;
        if (b1.rsp_dr !== '0) begin
            bad++; $display("FAIL reset_rsp_dr: got %h want 0", b1.rsp_dr);
        end
        total++;
        if ({b1.vji_tck, b1.vji_tdi, b1.vji_ir_in, b1.vji_uir, b1.vji_cdr, b1.vji_sdr, b1.vji_udr, b1.vji_rti} !== '0) begin
            bad++; $display("FAIL reset_vji: tck=%b tdi=%b ir=%b flags=%b%b%b%b%b want all 0",
                b1.vji_tck, b1.vji_tdi, b1.vji_ir_in, b1.vji_uir, b1.vji_cdr, b1.vji_sdr, b1.vji_udr, b1.vji_rti);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [DW-1:0] pat[4];
        logic [63:0]   r;
        logic [DW-1:0] want;
        r = {$urandom, $urandom};
        pat[0] = 38'h2A_5A5A_5A5A;
        pat[1] = '1;
        pat[2] = '0;
        pat[3] = r[DW-1:0];
        cmd1(2'b01, pat[0]);
        drain1();
        total++;
        if (b1.vji_ir_in !== 2'b01) begin
            bad++; $display("FAIL ir_in_hold: got %b want 01", b1.vji_ir_in);
        end
        want = 38'h14_B4B4_B4B4;
        repeat (5) @(negedge clk);
        total++;
        if (b1.rsp_dr !== want) begin
            bad++; $display("FAIL rsp_dr_hold: got %h want %h", b1.rsp_dr, want);
        end
        for (int i = 1; i < 4; i++) begin
            cmd1(IW'($urandom_range(0, 3)), pat[i]);
            drain1();
        end
    endtask

    task automatic test_ir_repeat();
        cmd1(2'b10, 38'h01_2345_6789);
        drain1();
        cmd1(2'b10, 38'h3E_DCBA_9876);
        drain1();
        cmd1(2'b11, 38'h15_5555_AAAA);
        drain1();
    endtask

    task automatic test_slave();
        exp_t          e;
        logic [63:0]   r;
        logic [DW-1:0] dr;
        int            n;
        r = {$urandom, $urandom};
        dr = r[DW-1:0];
        @(negedge clk);
        b2.cmd_valid = 1'b1; b2.cmd_ir = 2'b01; b2.cmd_dr = dr;
        e.dr = SLV; e.lat = (DW + 4) * 2; e.uir = 2;
        q2.push_back(e);
        @(negedge clk);
        b2.cmd_valid = 1'b0;
        n = 0;
        while (!(q2.size() == 0 && b2.cmd_ready) && n < 500) begin @(negedge clk); n++; end
        total++;
        if (q2.size() != 0 || !b2.cmd_ready) begin
            bad++; $display("FAIL drain2: outstanding=%0d cmd_ready=%b want 0/1", q2.size(), b2.cmd_ready);
            q2.delete();
        end
        total++;
        if (sr_q !== dr) begin
            bad++; $display("FAIL slave_shifted_in: got %h want %h", sr_q, dr);
        end
    endtask

    task automatic test_back_to_back();
        int            n;
        int            acc;
        logic [63:0]   r;
        acc_log.delete();
        rsp_log.delete();
        acc = 0;
        n = 0;
        b1.cmd_ir = 2'b01;
        while (acc < 2 && n < 1000) begin
            @(negedge clk);
            n++;
            r = {$urandom, $urandom};
            b1.cmd_dr = r[DW-1:0];
            b1.cmd_valid = 1'b1;
            if (b1.cmd_ready) begin
                push1(2'b01, r[DW-1:0]);
                acc++;
            end
        end
        @(negedge clk);
        b1.cmd_valid = 1'b0;
        drain1();
        total++;
        if (acc_log.size() != 2 || rsp_log.size() != 2) begin
            bad++; $display("FAIL b2b_counts: accepts=%0d rsps=%0d want 2/2", acc_log.size(), rsp_log.size());
        end else begin
            // rsp_valid cycle, one idle cycle, then the next accept edge.
            total++;
            if (acc_log[1] - rsp_log[0] !== 2) begin
                bad++; $display("FAIL b2b_gap: got %0d want 2", acc_log[1] - rsp_log[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        cmd1(2'b01, 38'h2B_CDEF_0123);
        repeat (40) @(posedge clk);
        #2;
        total++;
        if (b1.vji_sdr !== 1'b1) begin
            bad++; $display("FAIL mid_in_sdr: vji_sdr=%b want 1", b1.vji_sdr);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({b1.busy, b1.rsp_valid, b1.vji_tck, b1.vji_tdi, b1.vji_sdr, b1.vji_ir_in} !== '0 || b1.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL mid_async_reset: busy=%b rsp=%b tck=%b tdi=%b sdr=%b ir=%b ready=%b want 0,0,0,0,0,00,1",
                b1.busy, b1.rsp_valid, b1.vji_tck, b1.vji_tdi, b1.vji_sdr, b1.vji_ir_in, b1.cmd_ready);
        end
        q1.delete();
        m_v = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n = rsp_n1;
        repeat (250) @(negedge clk);
        total++;
        if (rsp_n1 !== n || b1.cmd_ready !== 1'b1 || b1.busy !== 1'b0) begin
            bad++; $display("FAIL mid_no_rsp: rsps=%0d want %0d ready=%b busy=%b", rsp_n1, n, b1.cmd_ready, b1.busy);
        end
    endtask

    task automatic test_protocol();
        total++;
        if (tdi_bad !== 0) begin bad++; $display("FAIL tdi_timing: got %0d want 0", tdi_bad); end
        total++;
        if (oh_bad + oh_bad2 !== 0) begin bad++; $display("FAIL flags_onehot: got %0d want 0", oh_bad + oh_bad2); end
        total++;
        if (ord_bad2 !== 0) begin bad++; $display("FAIL flag_order: got %0d want 0", ord_bad2); end
        total++;
        if (pulse_bad !== 0) begin bad++; $display("FAIL rsp_pulse_width: got %0d want 0", pulse_bad); end
        total++;
        if (idle_bad !== 0) begin bad++; $display("FAIL idle_quiet: got %0d want 0", idle_bad); end
    endtask

    initial begin
        b1.cmd_valid = 1'b0; b1.cmd_ir = '0; b1.cmd_dr = '0;
        b2.cmd_valid = 1'b0; b2.cmd_ir = '0; b2.cmd_dr = '0;
        test_reset();
        test_loopback();
        test_ir_repeat();
        test_slave();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
